// File: rtl/upsample_2d.sv
// Nearest-neighbour upsampler: each pixel repeats KER_SIZE_X times per row, and each row repeats KER_SIZE_Y times.
// One cycle from input accept to output; in_ready falls under output stall, on non-final replicas and during line replay.
module upsample_2d #(
   parameter int NBITS      = 8,
   parameter int NFMAPS     = 4,
   parameter int KER_SIZE_X = 2,
   parameter int KER_SIZE_Y = 2,
   parameter int IN_WIDTH   = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NBITS*NFMAPS-1:0] input_act,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NBITS*NFMAPS-1:0] output_act,
   output logic                    out_eol
);

   localparam int W  = NBITS * NFMAPS;
   localparam int CW = (IN_WIDTH   > 1) ? $clog2(IN_WIDTH)   : 1;
   localparam int XW = (KER_SIZE_X > 1) ? $clog2(KER_SIZE_X) : 1;
   localparam int YW = (KER_SIZE_Y > 1) ? $clog2(KER_SIZE_Y) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(IN_WIDTH - 1);
   localparam logic [XW-1:0] X_MAX   = XW'(KER_SIZE_X - 1);
   localparam logic [YW-1:0] Y_MAX   = YW'(KER_SIZE_Y - 1);

   typedef enum logic {FILL = 1'b0, REPLAY = 1'b1} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_col;
   logic [XW-1:0]   r_rep_x;
   logic [YW-1:0]   r_rep_y;
   logic            r_out_valid;
   logic [W-1:0]    r_output_act;
   logic            r_eol_col;
   logic [W-1:0]    r_linebuf [IN_WIDTH];

   logic            w_x_last;
   logic            w_load_ok;
   logic            w_load;
   logic            w_col_last;
   logic [W-1:0]    w_load_dat;

   always_comb begin
      w_x_last   = (r_rep_x == X_MAX);
      w_load_ok  = !r_out_valid || (out_ready && w_x_last);
      w_col_last = (r_col == COL_MAX);
      w_load     = 1'b0;
      w_load_dat = r_linebuf[r_col];
      in_ready   = 1'b0;
      if (rstn) begin
         if (r_state == FILL) begin
            in_ready   = w_load_ok;
            w_load     = w_load_ok && in_valid;
            w_load_dat = input_act;
         end else begin
            w_load     = w_load_ok;
         end
      end
   end

   // Line buffer is deliberately left out of reset; only FILL loads write it.
   always_ff @(posedge clk) begin
      if (w_load && (r_state == FILL)) begin
         r_linebuf[r_col] <= input_act;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= FILL;
         r_col        <= '0;
         r_rep_x      <= '0;
         r_rep_y      <= '0;
         r_out_valid  <= 1'b0;
         r_output_act <= '0;
         r_eol_col    <= 1'b0;
      end else if (w_load) begin
         // A load always wins over retiring the final replica, so no bubble appears.
         r_output_act <= w_load_dat;
         r_out_valid  <= 1'b1;
         r_rep_x      <= '0;
         r_eol_col    <= w_col_last;
         if (w_col_last) begin
            r_col <= '0;
            if (r_state == FILL) begin
               if (KER_SIZE_Y > 1) begin
                  r_state <= REPLAY;
                  r_rep_y <= YW'(1);
               end
            end else if (r_rep_y == Y_MAX) begin
               r_state <= FILL;
               r_rep_y <= '0;
            end else begin
               r_rep_y <= r_rep_y + YW'(1);
            end
         end else begin
            r_col <= r_col + CW'(1);
         end
      end else if (r_out_valid && out_ready) begin
         if (w_x_last) begin
            r_out_valid <= 1'b0;
         end else begin
            r_rep_x <= r_rep_x + XW'(1);
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign output_act = r_output_act;
   assign out_eol    = r_out_valid && w_x_last && r_eol_col;

endmodule

// File: doc/upsample_2d.md
# upsample_2d

Streaming nearest-neighbour upsampler, the inverse counterpart of `avg_pool_2d`. It takes a raster stream of pooled pixels, each carrying NFMAPS feature-map values. It emits the upsampled raster: every pixel repeats KER_SIZE_X times horizontally, and every row repeats KER_SIZE_Y times vertically. It sits on the decoder or expansion side of the network datapath and uses valid/ready handshakes on both sides, with a single-row line buffer for the vertical replay.

## Interface
- NBITS, 8, bits per feature value
- NFMAPS, 4, feature maps per pixel
- KER_SIZE_X, 2, horizontal replication factor (≥1)
- KER_SIZE_Y, 2, vertical replication factor (≥1)
- IN_WIDTH, 4, input pixels per row (≥1); line buffer depth
- clk  input  1  clock; all logic on rising edge
- rstn  input  1  synchronous active-low reset
- in_valid  input  1  input pixel valid
- in_ready  output  1  block accepts input pixel this cycle
- input_act  input  NBITS*NFMAPS  input pixel; fmap k at bits [k*NBITS +: NBITS]
- out_valid  output  1  output pixel valid
- out_ready  input  1  downstream accepts output pixel
- output_act  output  NBITS*NFMAPS  output pixel, same packing as input_act
- out_eol  output  1  high with out_valid on the last beat of each output row

## Operation
- Source state machine selects where the next output load comes from:
  - FILL: load from input_act.
  - REPLAY: load from line buffer.
- Counters:
  - col, 0..IN_WIDTH-1: column of the next load.
  - rep_y, 0..KER_SIZE_Y-1: row replica of the next load.
  - rep_x, 0..KER_SIZE_X-1: replica index of the beat currently held in the output register.
- x_last = (rep_x == KER_SIZE_X-1).
- load_ok = !out_valid || (out_ready && x_last).
- FILL: in_ready = load_ok.
  - On in_valid && in_ready: output_act <= input_act; linebuf[col] <= input_act; out_valid <= 1; rep_x <= 0; col++.
- REPLAY: in_ready = 0.
  - When load_ok: output_act <= linebuf[col]; out_valid <= 1; rep_x <= 0; col++.
- Output handshake with !x_last: rep_x++, data held.
- Output handshake with x_last and no load that cycle: out_valid <= 0.
- col wrap (load at col == IN_WIDTH-1): col <= 0.
  - From FILL: if KER_SIZE_Y > 1, go to REPLAY with rep_y <= 1; otherwise stay in FILL.
  - From REPLAY: if rep_y == KER_SIZE_Y-1, go to FILL with rep_y <= 0; otherwise rep_y++.
- out_eol = out_valid && x_last && (held beat was loaded from column IN_WIDTH-1). Implement it as a registered flag set on load.
- Data is copied bit-exact; no arithmetic on values.
- KER_SIZE_X = KER_SIZE_Y = 1 degenerates to a one-stage pipeline register, and the line buffer is unused.

## Timing
- Reset (rstn low at a clk edge) sets:
  - out_valid = 0, output_act = 0, out_eol = 0
  - state = FILL, col = 0, rep_x = 0, rep_y = 0
- in_ready is 0 while rstn is low. Line buffer contents are not reset.
- Reset mid-row or mid-replay discards all pending data. The first input accepted after reset is column 0 of a new row.
- Latency: an input accepted at edge N presents on output_act after edge N (visible in cycle N+1).
- Throughput with out_ready held high: one output beat per cycle with no bubbles, including at FILL↔REPLAY transitions and row boundaries.
- Each input row occupies IN_WIDTH*KER_SIZE_X*KER_SIZE_Y output beats.
- in_ready is low for all REPLAY loads and for the non-final horizontal replicas.
- Backpressure: while out_valid && !out_ready, output_act, out_eol and rep_x hold, and in_ready = 0.
- in_valid low in FILL: output drains to out_valid = 0. No load occurs until input arrives, and counters do not advance.
- Simultaneous final-replica handshake and new load in the same cycle: the new beat replaces the old one, and out_valid stays 1.

## Test plan
- Defaults. Feed row A..D, where pixel p has every fmap byte = p (0x01..0x04), out_ready = 1.
  -> Outputs 01,01,02,02,03,03,04,04 twice (16 beats), the first one cycle after A is accepted.
  -> out_eol on beats 8 and 16; in_ready low during beats 9–16.
- Two consecutive rows (0x01–0x04, then 0x11–0x14), in_valid always 1.
  -> 32 contiguous output beats with no gap; second row appears only after the replay of the first.
- Random out_ready (≈50%) on the default row.
  -> Identical 16-beat sequence. Output is stable while stalled, and no input is accepted during a stall.
- Assert rstn low for 1 cycle midway through the REPLAY of row 0x01–0x04, then feed 0x21–0x24.
  -> out_valid = 0 the cycle after reset. Output is exactly the 16-beat sequence of 0x21–0x24, with no stale 0x0x values.
- KER_SIZE_X = 1, KER_SIZE_Y = 1, IN_WIDTH = 3; stream 0xA1, 0xA2, 0xA3.
  -> Same values out, each one cycle later; out_eol on 0xA3.
- Chain with avg_pool_2d (2x2) on the upsampled output, using random input pixels.
  -> Pooled result equals the original input bit-exact.
